mini_mips: RTL and testbench



---
 rtl/mini_mips_pkg.sv | 66 ++++++
 rtl/mini_mips_alu.sv | 36 +++
 rtl/mini_mips_dm.sv | 31 +++
 rtl/mini_mips_im.sv | 18 +
 rtl/mini_mips_rb.sv | 42 ++++
 rtl/mini_mips.sv | 211 +++++++++++++++++++++
 tb/tb_mini_mips.sv | 218 +++++++++++++++++++++
 7 files changed

// File: rtl/mini_mips_pkg.sv
// mini_mips_pkg
// Shared definitions for the mini_mips core: storage depths, instruction
// field positions, opcode/funct encodings and the ALU operation enum.
// No ports; imported by every mini_mips module.
package mini_mips_pkg;

  // Storage depths
  localparam int NumRegs   = 8;
  localparam int ImemDepth = 32;
  localparam int DmemDepth = 64;

  // Instruction field positions (16-bit instruction word)
  localparam int OpMsb   = 15;
  localparam int OpLsb   = 12;
  localparam int RsMsb   = 11;
  localparam int RsLsb   = 9;
  localparam int RtMsb   = 8;
  localparam int RtLsb   = 6;
  localparam int RdMsb   = 5;
  localparam int RdLsb   = 3;
  localparam int FnMsb   = 2;
  localparam int FnLsb   = 0;
  localparam int ImmMsb  = 5;
  localparam int ImmLsb  = 0;
  localparam int AddrMsb = 11;
  localparam int AddrLsb = 0;

  // Opcodes; 1100-1111 are unassigned and behave as NOPs
  localparam logic [3:0] OpRType = 4'b0000;
  localparam logic [3:0] OpAddi  = 4'b0001;
  localparam logic [3:0] OpAndi  = 4'b0010;
  localparam logic [3:0] OpOri   = 4'b0011;
  localparam logic [3:0] OpLw    = 4'b0100;
  localparam logic [3:0] OpSw    = 4'b0101;
  localparam logic [3:0] OpBeq   = 4'b0110;
  localparam logic [3:0] OpBne   = 4'b0111;
  localparam logic [3:0] OpSlti  = 4'b1000;
  localparam logic [3:0] OpJ     = 4'b1001;
  localparam logic [3:0] OpJal   = 4'b1010;
  localparam logic [3:0] OpJr    = 4'b1011;

  // R-type funct codes
  localparam logic [2:0] FnAdd  = 3'b000;
  localparam logic [2:0] FnSub  = 3'b001;
  localparam logic [2:0] FnAnd  = 3'b010;
  localparam logic [2:0] FnOr   = 3'b011;
  localparam logic [2:0] FnSlt  = 3'b100;
  localparam logic [2:0] FnNor  = 3'b101;
  localparam logic [2:0] FnSllv = 3'b110;
  localparam logic [2:0] FnSrlv = 3'b111;

  // jal always links into R7
  localparam logic [2:0] LinkReg = 3'd7;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt,
    AluNor,
    AluSllv,
    AluSrlv
  } aluCtrl_e;

endpackage

// File: rtl/mini_mips_alu.sv
// mini_mips_alu
// 32-bit combinational ALU with wrap-around arithmetic.
// Ports:
//   a_i, b_i  - operands (a is always rs; b is rt or the extended immediate)
//   ctrl_i    - operation select
//   result_o  - operation result
//   zero_o    - high when result_o is zero (used for beq/bne)
module mini_mips_alu
  import mini_mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  aluCtrl_e    ctrl_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  // Shift amounts only use the low five bits of b so shifts stay in range.
  always_comb begin
    result_o = '0;
    case (ctrl_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluSlt:  result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      AluNor:  result_o = ~(a_i | b_i);
      AluSllv: result_o = a_i << b_i[4:0];
      AluSrlv: result_o = a_i >> b_i[4:0];
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/mini_mips_dm.sv
// mini_mips_dm
// Data memory, 64 x 32 bits, combinational read, falling-edge write.
// Not cleared by reset; preloadable through dm.data.
// Ports:
//   clk          - clock (write on falling edge)
//   addr_i       - word address
//   writeEn_i    - write enable (already qualified with reset by the core)
//   writeData_i  - store data
//   readData_o   - load data at addr_i
module mini_mips_dm
  import mini_mips_pkg::*;
(
  input  logic        clk,
  input  logic [5:0]  addr_i,
  input  logic        writeEn_i,
  input  logic [31:0] writeData_i,
  output logic [31:0] readData_o
);

  logic [31:0] data [0:DmemDepth-1];

  // Store commits mid-cycle, matching the register file write timing.
  always_ff @(negedge clk) begin
    if (writeEn_i) begin
      data[addr_i] <= writeData_i;
    end
  end

  assign readData_o = data[addr_i];

endmodule

// File: rtl/mini_mips_im.sv
// mini_mips_im
// Instruction ROM, 32 x 16 bits, combinational read. Contents are loaded
// from outside the design through the hierarchical path im.instructions.
// Ports:
//   addr_i  - word address (low five bits of the PC)
//   instr_o - instruction word at addr_i
module mini_mips_im
  import mini_mips_pkg::*;
(
  input  logic [4:0]  addr_i,
  output logic [15:0] instr_o
);

  logic [15:0] instructions [0:ImemDepth-1];

  assign instr_o = instructions[addr_i];

endmodule

// File: rtl/mini_mips_rb.sv
// mini_mips_rb
// Register file, 8 x 32 bits, two combinational read ports and one write
// port committed on the falling clock edge. R0 is hard-wired to zero.
// Ports:
//   clk, reset              - clock and asynchronous active-high reset
//   readAddr1_i/readAddr2_i - read port addresses (rs, rt)
//   readData1_o/readData2_o - read port data
//   writeEn_i, writeAddr_i, writeData_i - write port
module mini_mips_rb
  import mini_mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  readAddr1_i,
  input  logic [2:0]  readAddr2_i,
  output logic [31:0] readData1_o,
  output logic [31:0] readData2_o,
  input  logic        writeEn_i,
  input  logic [2:0]  writeAddr_i,
  input  logic [31:0] writeData_i
);

  logic [31:0] registers [0:NumRegs-1];

  // Writes land mid-cycle on the falling edge so that the PC (updated on the
  // rising edge) is stable; reset clears the file immediately and, while
  // held, suppresses every write. Writes aimed at R0 are dropped.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        registers[i] <= '0;
      end
    end else if (writeEn_i && (writeAddr_i != 3'd0)) begin
      registers[writeAddr_i] <= writeData_i;
    end
  end

  // R0 is forced to read zero regardless of array contents.
  assign readData1_o = (readAddr1_i == 3'd0) ? 32'd0 : registers[readAddr1_i];
  assign readData2_o = (readAddr2_i == 3'd0) ? 32'd0 : registers[readAddr2_i];

endmodule

// File: rtl/mini_mips.sv
// mini_mips
// Single-cycle 16-bit-instruction / 32-bit-datapath MIPS-style core. The PC
// is held outside: each cycle the core executes the instruction at Counter
// and presents the next PC combinationally on NewCounter.
// Ports:
//   NewCounter - next PC (forced to 0 while reset is asserted)
//   Counter    - current PC, word index into instruction memory
//   clk        - clock; state commits on the falling edge
//   reset      - asynchronous active-high reset
module mini_mips
  import mini_mips_pkg::*;
(
  output logic [31:0] NewCounter,
  input  logic [31:0] Counter,
  input  logic        clk,
  input  logic        reset
);

  logic [15:0] Instruction;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] ALURes;

  logic [3:0]  opField;
  logic [2:0]  rsField;
  logic [2:0]  rtField;
  logic [2:0]  rdField;
  logic [2:0]  fnField;
  logic [5:0]  immField;
  logic [11:0] addrField;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] pc1;
  logic [31:0] branchTarget;

  aluCtrl_e    aluCtrl;
  logic        useImm;
  logic        immZero;
  logic        regWrite;
  logic [2:0]  writeAddr;
  logic        memWrite;
  logic        memToReg;
  logic        linkPc;
  logic        isBeq;
  logic        isBne;
  logic        isJump;
  logic        isJr;

  logic [31:0] aluB;
  logic        aluZero;
  logic        branchTaken;
  logic [31:0] loadData;
  logic [31:0] writeData;
  logic        memWriteEn;

  mini_mips_im im (
    .addr_i  (Counter[4:0]),
    .instr_o (Instruction)
  );

  assign opField   = Instruction[OpMsb:OpLsb];
  assign rsField   = Instruction[RsMsb:RsLsb];
  assign rtField   = Instruction[RtMsb:RtLsb];
  assign rdField   = Instruction[RdMsb:RdLsb];
  assign fnField   = Instruction[FnMsb:FnLsb];
  assign immField  = Instruction[ImmMsb:ImmLsb];
  assign addrField = Instruction[AddrMsb:AddrLsb];

  assign sext         = {{26{immField[5]}}, immField};
  assign zext         = {26'b0, immField};
  assign pc1          = Counter + 32'd1;
  assign branchTarget = pc1 + sext;

  // Main decoder. Defaults describe a NOP, so unassigned opcodes
  // (1100-1111) fall through with no writes and a plain PC+1.
  always_comb begin
    aluCtrl   = AluAdd;
    useImm    = 1'b0;
    immZero   = 1'b0;
    regWrite  = 1'b0;
    writeAddr = rtField;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    linkPc    = 1'b0;
    isBeq     = 1'b0;
    isBne     = 1'b0;
    isJump    = 1'b0;
    isJr      = 1'b0;
    case (opField)
      OpRType: begin
        regWrite  = 1'b1;
        writeAddr = rdField;
        case (fnField)
          FnAdd:   aluCtrl = AluAdd;
          FnSub:   aluCtrl = AluSub;
          FnAnd:   aluCtrl = AluAnd;
          FnOr:    aluCtrl = AluOr;
          FnSlt:   aluCtrl = AluSlt;
          FnNor:   aluCtrl = AluNor;
          FnSllv:  aluCtrl = AluSllv;
          FnSrlv:  aluCtrl = AluSrlv;
          default: aluCtrl = AluAdd;
        endcase
      end
      OpAddi: begin
        regWrite = 1'b1;
        useImm   = 1'b1;
      end
      OpAndi: begin
        regWrite = 1'b1;
        useImm   = 1'b1;
        immZero  = 1'b1;
        aluCtrl  = AluAnd;
      end
      OpOri: begin
        regWrite = 1'b1;
        useImm   = 1'b1;
        immZero  = 1'b1;
        aluCtrl  = AluOr;
      end
      OpSlti: begin
        regWrite = 1'b1;
        useImm   = 1'b1;
        aluCtrl  = AluSlt;
      end
      OpLw: begin
        regWrite = 1'b1;
        useImm   = 1'b1;
        memToReg = 1'b1;
      end
      OpSw: begin
        useImm   = 1'b1;
        memWrite = 1'b1;
      end
      OpBeq: begin
        aluCtrl = AluSub;
        isBeq   = 1'b1;
      end
      OpBne: begin
        aluCtrl = AluSub;
        isBne   = 1'b1;
      end
      OpJ: begin
        isJump = 1'b1;
      end
      OpJal: begin
        isJump    = 1'b1;
        linkPc    = 1'b1;
        regWrite  = 1'b1;
        writeAddr = LinkReg;
      end
      OpJr: begin
        isJr = 1'b1;
      end
      default: ;
    endcase
  end

  mini_mips_rb rb (
    .clk         (clk),
    .reset       (reset),
    .readAddr1_i (rsField),
    .readAddr2_i (rtField),
    .readData1_o (ReadData1),
    .readData2_o (ReadData2),
    .writeEn_i   (regWrite),
    .writeAddr_i (writeAddr),
    .writeData_i (writeData)
  );

  assign aluB = useImm ? (immZero ? zext : sext) : ReadData2;

  mini_mips_alu alu (
    .a_i      (ReadData1),
    .b_i      (aluB),
    .ctrl_i   (aluCtrl),
    .result_o (ALURes),
    .zero_o   (aluZero)
  );

  // Reset has no hold on the data memory contents, so store suppression
  // during reset is done here rather than inside dm.
  assign memWriteEn = memWrite & ~reset;

  mini_mips_dm dm (
    .clk         (clk),
    .addr_i      (ALURes[5:0]),
    .writeEn_i   (memWriteEn),
    .writeData_i (ReadData2),
    .readData_o  (loadData)
  );

  assign writeData   = memToReg ? loadData : (linkPc ? pc1 : ALURes);
  assign branchTaken = (isBeq & aluZero) | (isBne & ~aluZero);

  // Next-PC selection; reset dominates so the harness restarts at 0.
  always_comb begin
    if (reset) begin
      NewCounter = 32'd0;
    end else if (isJump) begin
      NewCounter = {20'b0, addrField};
    end else if (isJr) begin
      NewCounter = ReadData1;
    end else if (branchTaken) begin
      NewCounter = branchTarget;
    end else begin
      NewCounter = pc1;
    end
  end

endmodule

// File: tb/tb_mini_mips.sv
// tb_mini_mips
// Self-checking bench for mini_mips. The bench plays the role of the PC
// harness: it writes an instruction into im, drives Counter just after the
// rising edge, checks NewCounter before the falling edge and checks the
// committed register/memory state just after the falling edge.
module tb_mini_mips;

  localparam int KNext = 0;
  localparam int KReg  = 1;
  localparam int KMem  = 2;
  localparam int KRd1  = 3;
  localparam int KRd2  = 4;

  typedef struct {
    string       name;
    int          phase;
    int          kind;
    int          idx;
    logic [31:0] expVal;
  } scoreItem_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [31:0] pc;
    logic [31:0] expNext;
    int          kind;
    int          idx;
    logic [31:0] expVal;
  } vector_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Counter;
  logic [31:0] NewCounter;

  scoreItem_t scoreQ[$];
  vector_t    vecs[$];
  int         compared   = 0;
  int         mismatched = 0;

  mini_mips dut (
    .NewCounter (NewCounter),
    .Counter    (Counter),
    .clk        (clk),
    .reset      (reset)
  );

  // Free-running clock: rising edges at 5,15,..., falling edges at 10,20,...
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] rType(logic [2:0] rs, logic [2:0] rt,
                                         logic [2:0] rd, logic [2:0] fn);
    return {4'b0000, rs, rt, rd, fn};
  endfunction

  function automatic logic [15:0] iType(logic [3:0] op, logic [2:0] rs,
                                         logic [2:0] rt, logic [5:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [15:0] jType(logic [3:0] op, logic [11:0] addr);
    return {op, addr};
  endfunction

  function automatic logic [31:0] observe(int kind, int idx);
    case (kind)
      KNext:   return NewCounter;
      KReg:    return dut.rb.registers[idx];
      KMem:    return dut.dm.data[idx];
      KRd1:    return dut.ReadData1;
      default: return dut.ReadData2;
    endcase
  endfunction

  task automatic compare(string name, logic [31:0] act, logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expectItem(string name, int phase, int kind, int idx, logic [31:0] expv);
    scoreItem_t item;
    item.name   = name;
    item.phase  = phase;
    item.kind   = kind;
    item.idx    = idx;
    item.expVal = expv;
    scoreQ.push_back(item);
  endtask

  // Pops and compares every queued expectation belonging to this phase.
  task automatic checkOutput(int phase);
    scoreItem_t item;
    while (scoreQ.size() > 0 && scoreQ[0].phase == phase) begin
      item = scoreQ.pop_front();
      compare(item.name, observe(item.kind, item.idx), item.expVal);
    end
  endtask

  // One full cycle: load instruction, drive PC, check next PC, then check
  // the state committed at the falling edge.
  task automatic applyStimulus(vector_t v);
    logic [4:0] slot;
    @(posedge clk);
    #1;
    slot = v.pc[4:0];
    dut.im.instructions[slot] = v.instr;
    Counter = v.pc;
    expectItem({v.name, "/next"}, 0, KNext, 0, v.expNext);
    expectItem({v.name, "/state"}, 1, v.kind, v.idx, v.expVal);
    #1;
    checkOutput(0);
    @(negedge clk);
    #1;
    checkOutput(1);
  endtask

  initial begin
    // Build the vector table; each row depends on state left by earlier rows.
    vecs.push_back('{"add",   rType(3'd1, 3'd2, 3'd3, 3'b000), 32'd0,  32'd1,  KReg, 3, 32'd12});
    vecs.push_back('{"sub",   rType(3'd1, 3'd2, 3'd4, 3'b001), 32'd1,  32'd2,  KReg, 4, 32'hFFFF_FFFE});
    vecs.push_back('{"slt",   rType(3'd1, 3'd2, 3'd5, 3'b100), 32'd2,  32'd3,  KReg, 5, 32'd1});
    vecs.push_back('{"and",   rType(3'd1, 3'd2, 3'd6, 3'b010), 32'd3,  32'd4,  KReg, 6, 32'd5});
    vecs.push_back('{"or",    rType(3'd1, 3'd2, 3'd6, 3'b011), 32'd4,  32'd5,  KReg, 6, 32'd7});
    vecs.push_back('{"nor",   rType(3'd1, 3'd2, 3'd6, 3'b101), 32'd5,  32'd6,  KReg, 6, 32'hFFFF_FFF8});
    vecs.push_back('{"sllv",  rType(3'd1, 3'd2, 3'd6, 3'b110), 32'd6,  32'd7,  KReg, 6, 32'h0000_0280});
    vecs.push_back('{"srlv",  rType(3'd4, 3'd1, 3'd6, 3'b111), 32'd7,  32'd8,  KReg, 6, 32'h07FF_FFFF});
    vecs.push_back('{"sltneg",rType(3'd4, 3'd1, 3'd6, 3'b100), 32'd8,  32'd9,  KReg, 6, 32'd1});
    vecs.push_back('{"addi",  iType(4'b0001, 3'd0, 3'd1, 6'd3),  32'd9,  32'd10, KReg, 1, 32'd3});
    vecs.push_back('{"sw",    iType(4'b0101, 3'd1, 3'd1, 6'd2),  32'd10, 32'd11, KMem, 5, 32'd3});
    vecs.push_back('{"lw",    iType(4'b0100, 3'd1, 3'd6, 6'd2),  32'd11, 32'd12, KReg, 6, 32'd3});
    vecs.push_back('{"andi",  iType(4'b0010, 3'd4, 3'd6, 6'h3F), 32'd12, 32'd13, KReg, 6, 32'h0000_003E});
    vecs.push_back('{"ori",   iType(4'b0011, 3'd0, 3'd6, 6'h30), 32'd13, 32'd14, KReg, 6, 32'h0000_0030});
    vecs.push_back('{"slti",  iType(4'b1000, 3'd4, 3'd6, 6'h3F), 32'd14, 32'd15, KReg, 6, 32'd1});
    vecs.push_back('{"addineg",iType(4'b0001, 3'd1, 3'd6, 6'h3C),32'd15, 32'd16, KReg, 6, 32'hFFFF_FFFF});
    vecs.push_back('{"r0wr",  iType(4'b0001, 3'd0, 3'd0, 6'd9),  32'd16, 32'd17, KRd1, 0, 32'd0});
    vecs.push_back('{"nop",   iType(4'b1100, 3'd1, 3'd6, 6'h3F), 32'd17, 32'd18, KReg, 6, 32'hFFFF_FFFF});
    vecs.push_back('{"setr1", iType(4'b0001, 3'd0, 3'd1, 6'd4),  32'd18, 32'd19, KReg, 1, 32'd4});
    vecs.push_back('{"setr2", iType(4'b0001, 3'd0, 3'd2, 6'd4),  32'd19, 32'd20, KReg, 2, 32'd4});
    vecs.push_back('{"beqT",  iType(4'b0110, 3'd1, 3'd2, 6'h3E), 32'd10, 32'd9,  KRd2, 0, 32'd4});
    vecs.push_back('{"bneN",  iType(4'b0111, 3'd1, 3'd2, 6'h3E), 32'd10, 32'd11, KRd2, 0, 32'd4});
    vecs.push_back('{"beqN",  iType(4'b0110, 3'd1, 3'd3, 6'h3E), 32'd10, 32'd11, KRd2, 0, 32'd12});
    vecs.push_back('{"bneT",  iType(4'b0111, 3'd1, 3'd3, 6'h3E), 32'd10, 32'd9,  KRd2, 0, 32'd12});
    vecs.push_back('{"jal",   jType(4'b1010, 12'd20),            32'd4,  32'd20, KReg, 7, 32'd5});
    vecs.push_back('{"jr",    {4'b1011, 3'd7, 9'd0},             32'd20, 32'd5,  KReg, 7, 32'd5});
    vecs.push_back('{"j",     jType(4'b1001, 12'hFFF),           32'd21, 32'd4095, KReg, 7, 32'd5});

    // Reset state: registers clear as soon as reset rises, PC forced to 0.
    reset   = 1'b0;
    Counter = 32'd0;
    for (int i = 0; i < 32; i++) dut.im.instructions[i] = 16'hF000;
    for (int i = 0; i < 64; i++) dut.dm.data[i] = 32'd0;
    dut.rb.registers[3] = 32'h1234_5678;
    #1;
    reset = 1'b1;
    #1;
    expectItem("rst/next", 0, KNext, 0, 32'd0);
    expectItem("rst/r3",   0, KReg,  3, 32'd0);
    expectItem("rst/r7",   0, KReg,  7, 32'd0);
    checkOutput(0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    dut.rb.registers[1] = 32'd5;
    dut.rb.registers[2] = 32'd7;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Mid-cycle reset: R1 clears at once, PC forced to 0, pending sw blocked.
    applyStimulus('{"setr1b", iType(4'b0001, 3'd0, 3'd1, 6'd5), 32'd0, 32'd1, KReg, 1, 32'd5});
    dut.dm.data[0] = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    dut.im.instructions[1] = iType(4'b0101, 3'd0, 3'd1, 6'd0);
    Counter = 32'd1;
    #1;
    expectItem("pre/next", 0, KNext, 0, 32'd2);
    checkOutput(0);
    reset = 1'b1;
    #1;
    expectItem("midrst/r1",   0, KReg,  1, 32'd0);
    expectItem("midrst/next", 0, KNext, 0, 32'd0);
    expectItem("midrst/rd2",  0, KRd2,  0, 32'd0);
    checkOutput(0);
    @(negedge clk);
    #1;
    expectItem("midrst/noSw", 1, KMem, 0, 32'hAAAA_AAAA);
    expectItem("midrst/r2",   1, KReg, 2, 32'd0);
    checkOutput(1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    expectItem("postrst/next", 0, KNext, 0, 32'd2);
    checkOutput(0);

    if (scoreQ.size() != 0) begin
      compare("scoreQ/empty", scoreQ.size(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
